// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment encodings and digit geometry for the seven-segment scanner.
package seg7_pkg;

   localparam int NUM_DIGITS = 4;

   // Segment byte layout {a,b,c,d,e,f,g,dp}
   localparam int SEG_A  = 7;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   typedef logic [7:0] seg_t;
   typedef logic [1:0] digit_t;

   localparam seg_t HEX_0 = 8'hFC;
   localparam seg_t HEX_1 = 8'h60;
   localparam seg_t HEX_2 = 8'hDA;
   localparam seg_t HEX_3 = 8'hF2;
   localparam seg_t HEX_4 = 8'h66;
   localparam seg_t HEX_5 = 8'hB6;
   localparam seg_t HEX_6 = 8'hBE;
   localparam seg_t HEX_7 = 8'hE0;
   localparam seg_t HEX_8 = 8'hFE;
   localparam seg_t HEX_9 = 8'hF6;
   localparam seg_t HEX_A = 8'hEE;
   localparam seg_t HEX_B = 8'h3E;
   localparam seg_t HEX_C = 8'h9C;
   localparam seg_t HEX_D = 8'h7A;
   localparam seg_t HEX_E = 8'h9E;
   localparam seg_t HEX_F = 8'h8E;

   function automatic seg_t hex_seg(input logic [3:0] nib);
      case (nib)
         4'h0:    return HEX_0;
         4'h1:    return HEX_1;
         4'h2:    return HEX_2;
         4'h3:    return HEX_3;
         4'h4:    return HEX_4;
         4'h5:    return HEX_5;
         4'h6:    return HEX_6;
         4'h7:    return HEX_7;
         4'h8:    return HEX_8;
         4'h9:    return HEX_9;
         4'hA:    return HEX_A;
         4'hB:    return HEX_B;
         4'hC:    return HEX_C;
         4'hD:    return HEX_D;
         4'hE:    return HEX_E;
         default: return HEX_F;
      endcase
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex nibble to segment byte; the dp bit is always left clear.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [7:0] seg
);

   seg_t full;

   assign full = hex_seg(nibble);
   assign seg  = {full[SEG_A:SEG_G], 1'b0};

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: frame-coherent, time-multiplexed 4-digit seven-segment driver.
// Optional SEG7_LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 always shown).
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV   = 100000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [15:0]           value,
   input  logic                  value_valid,
   input  logic [3:0]            dp_mask,
   input  logic                  blank,
   output logic                  update_ack,
   output logic [NUM_DIGITS-1:0] bcd_choose,
   output logic [7:0]            bcd_display
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
   localparam logic [NUM_DIGITS-1:0] CHOOSE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [7:0] DISP_OFF = {8{ACTIVE_LOW}};

   if (SCAN_DIV < 2) begin : g_bad_div
      $error("seg7_scan: SCAN_DIV must be >= 2");
   end

   logic [CW-1:0]         cnt;
   digit_t                idx, idx_nx;
   logic [19:0]           pending, shadow, shadow_nx, strobe_word;
   logic                  pend_flag, tick, wrap, commit, lead_blank, dp;
   logic [15:0]           digits;
   logic [3:0]            dps, nib;
   logic [7:0]            seg, disp_nx;
   logic [NUM_DIGITS-1:0] choose_nx;

   assign tick        = cnt == LAST;
   assign idx_nx      = idx + 2'd1;
   assign wrap        = tick && idx == 2'd3;
   assign commit      = wrap && (value_valid || pend_flag);
   assign strobe_word = {dp_mask, value};
   // A strobe landing on the wrap edge goes straight to the display, newer than anything pending
   assign shadow_nx   = commit ? (value_valid ? strobe_word : pending) : shadow;
   assign digits      = shadow_nx[15:0];
   assign dps         = shadow_nx[19:16];
   assign nib         = digits[{idx_nx, 2'b00} +: 4];
   assign dp          = dps[idx_nx];

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   assign lead_blank = idx_nx != 2'd0 && (digits >> {idx_nx, 2'b00}) == 16'd0;
`else
   assign lead_blank = 1'b0;
`endif

   seg7_decode u_decode (
      .nibble (nib),
      .seg    (seg)
   );

   always_comb begin
      choose_nx = blank ? '0 : NUM_DIGITS'(1) << idx_nx;
      disp_nx = lead_blank ? 8'h00 : seg;
      disp_nx[SEG_DP] = dp;
      disp_nx = blank ? 8'h00 : disp_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         idx         <= '0;
         pending     <= '0;
         pend_flag   <= 1'b0;
         shadow      <= '0;
         update_ack  <= 1'b0;
         bcd_choose  <= CHOOSE_OFF;
         bcd_display <= DISP_OFF;
      end else begin
         cnt        <= tick ? '0 : cnt + 1'b1;
         shadow     <= shadow_nx;
         update_ack <= commit;
         pend_flag  <= commit ? 1'b0 : (value_valid ? 1'b1 : pend_flag);
         if (value_valid) pending <= strobe_word;
         if (tick) begin
            idx         <= idx_nx;
            bcd_choose  <= choose_nx ^ CHOOSE_OFF;
            bcd_display <= disp_nx ^ DISP_OFF;
         end
      end
   end

endmodule
